// File: rtl/fb_pkg.sv
// Shared constants, write-phase enum and colour expansion for the framebuffer painter.
package fb_pkg;

  localparam int unsigned FB_ADDR_W = 12;
  localparam int unsigned FB_WORD_W = 12;
  localparam int unsigned FB_BPC    = 4;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } wr_phase_e;

  // Replicate a stored nibble into a full 8-bit channel (4'hA -> 8'hAA).
  function automatic logic [7:0] fb_expand(input logic [FB_BPC-1:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// 4096x12 simple dual-port RAM: one write port, one registered read port.
// Shaped to map onto iCE40 SB_RAM40_4K; a same-address read during a write
// returns the old contents.
// Ports: pll_clk; we/waddr/wdata write port; raddr in, rdata registered out.
module fb_ram
  import fb_pkg::*;
(
  input  logic                 pll_clk,
  input  logic                 we,
  input  logic [FB_ADDR_W-1:0] waddr,
  input  logic [FB_WORD_W-1:0] wdata,
  input  logic [FB_ADDR_W-1:0] raddr,
  output logic [FB_WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << FB_ADDR_W;

  logic [FB_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge pll_clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_painter.sv
// Framebuffer-backed pixel source for the LED panel scan driver.
// Pixels arrive as an R,G,B byte stream in raster order; the upper nibble of
// each byte is stored. Queries (x, y) return {R8,G8,B8} one cycle later.
// Ports: pll_clk, reset (sync, active-high); frame (swap trigger only);
//   x/y query, rgb result; wr_valid/wr_ready/wr_data/wr_sof byte stream;
//   frame_done pulse on the final pixel write of a frame.
// Build option: FB_PAINTER_DOUBLE_BUFFER_EN adds a second bank, with the
//   front bank swapped on the first frame change after a completed frame.
module fb_painter
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 64,
  parameter int unsigned BPC    = 4
) (
  input  logic                      pll_clk,
  input  logic                      reset,
  input  logic [12:0]               frame,
  input  logic [$clog2(WIDTH):0]    x,
  input  logic [$clog2(HEIGHT)-1:0] y,
  output logic [23:0]               rgb,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [7:0]                wr_data,
  input  logic                      wr_sof,
  output logic                      frame_done
);

  localparam int unsigned XW = $clog2(WIDTH);

  wr_phase_e            phase;
  logic [BPC-1:0]       r_q;
  logic [BPC-1:0]       g_q;
  logic [FB_ADDR_W-1:0] pix_addr;
  logic [FB_ADDR_W-1:0] wr_addr_q;
  logic [FB_WORD_W-1:0] wr_word_q;
  logic                 wr_en_q;
  logic                 off_q;
  logic [FB_WORD_W-1:0] rd_word;

  logic                 accept_c;
  logic [BPC-1:0]       nib_c;
  logic                 last_pix_c;
  logic [FB_ADDR_W-1:0] rd_addr_c;

  assign accept_c   = wr_valid && wr_ready;
  assign nib_c      = wr_data[7 -: BPC];
  assign last_pix_c = (pix_addr == '1);
  assign rd_addr_c  = FB_ADDR_W'({y, x[XW-1:0]});

  // Byte-stream assembly: capture R and G, emit a RAM write after B.
  always_ff @(posedge pll_clk) begin
    if (reset) begin
      phase      <= PH_R;
      pix_addr   <= '0;
      r_q        <= '0;
      g_q        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_word_q  <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      frame_done <= 1'b0;
      if (accept_c) begin
        if (wr_sof) begin
          // Resync: this byte is R of pixel 0; any partial pixel is dropped.
          pix_addr <= '0;
          r_q      <= nib_c;
          phase    <= PH_G;
        end else begin
          case (phase)
            PH_R: begin
              r_q   <= nib_c;
              phase <= PH_G;
            end
            PH_G: begin
              g_q   <= nib_c;
              phase <= PH_B;
            end
            default: begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= pix_addr;
              wr_word_q  <= FB_WORD_W'({r_q, g_q, nib_c});
              pix_addr   <= pix_addr + FB_ADDR_W'(1);
              phase      <= PH_R;
              frame_done <= last_pix_c;
            end
          endcase
        end
      end
    end
  end

  // Off-panel flag travels alongside the registered RAM read.
  always_ff @(posedge pll_clk) begin
    if (reset) off_q <= 1'b1;
    else       off_q <= x[XW];
  end

`ifdef FB_PAINTER_DOUBLE_BUFFER_EN
  logic                 front_sel;
  logic                 swap_pending;
  logic                 rd_sel_q;
  logic [12:0]          frame_q;
  logic [FB_WORD_W-1:0] rdata0;
  logic [FB_WORD_W-1:0] rdata1;
  logic                 frame_last_c;
  logic                 swap_now_c;

  assign frame_last_c = accept_c && !wr_sof && (phase == PH_B) && last_pix_c;
  assign swap_now_c   = swap_pending && (frame != frame_q);

  // Bank swap: a completed frame stalls the stream until the scan frame advances.
  always_ff @(posedge pll_clk) begin
    frame_q <= frame;
    if (reset) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      rd_sel_q     <= 1'b0;
      wr_ready     <= 1'b0;
    end else begin
      rd_sel_q <= front_sel;
      if (swap_now_c) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
        wr_ready     <= 1'b1;
      end else if (frame_last_c) begin
        swap_pending <= 1'b1;
        wr_ready     <= 1'b0;
      end else begin
        wr_ready <= ~swap_pending;
      end
    end
  end

  // Writes always target the back bank as selected during the write cycle.
  fb_ram u_ram0 (
    .pll_clk (pll_clk),
    .we      (wr_en_q && front_sel),
    .waddr   (wr_addr_q),
    .wdata   (wr_word_q),
    .raddr   (rd_addr_c),
    .rdata   (rdata0)
  );

  fb_ram u_ram1 (
    .pll_clk (pll_clk),
    .we      (wr_en_q && !front_sel),
    .waddr   (wr_addr_q),
    .wdata   (wr_word_q),
    .raddr   (rd_addr_c),
    .rdata   (rdata1)
  );

  assign rd_word = rd_sel_q ? rdata1 : rdata0;
`else
  logic unused_frame;
  assign unused_frame = ^frame;

  // Single bank never back-pressures: one write per three bytes.
  always_ff @(posedge pll_clk) begin
    if (reset) wr_ready <= 1'b0;
    else       wr_ready <= 1'b1;
  end

  fb_ram u_ram (
    .pll_clk (pll_clk),
    .we      (wr_en_q),
    .waddr   (wr_addr_q),
    .wdata   (wr_word_q),
    .raddr   (rd_addr_c),
    .rdata   (rd_word)
  );
`endif

  assign rgb = off_q ? 24'h0 : {fb_expand(rd_word[11:8]),
                                fb_expand(rd_word[7:4]),
                                fb_expand(rd_word[3:0])};

endmodule
